joyport_owner_arbiter: RTL and testbench

//  Shares MSX joystick port A between the USB/HPS gamepad (joy_0) and the PS/2 mouse strobe-protocol

---
 rtl/joyport_owner_arbiter.sv | 172 +++++++++++++++++
 tb/tb_joyport_owner_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joyport_owner_arbiter.sv
// Purpose : hands MSX joystick port A to either the gamepad or the PS/2 mouse engine; optional JOYPORT_SWCOUNT_EN adds sw_count.
// Latency : port_data is registered, 1 cycle from joy/mouse_data; ownership moves only after the strobe line has been quiet.
// Backpres: none; inputs are sampled every cycle, and requests seen during the hold window or while busy are dropped.
module joyport_owner_arbiter #(
   parameter int QUIET_CYCLES = 21477,
   parameter int HOLD_CYCLES  = 2147727,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       soft_rst,
   input  logic [5:0] joy,
   input  logic       ps2_mouse_clk,
   input  logic [5:0] mouse_data,
   input  logic       strobe_in,
   output logic [5:0] port_data,
   output logic       owner_mouse,
   output logic       pending
`ifdef JOYPORT_SWCOUNT_EN
   ,
   output logic [7:0] sw_count
`endif
);

   localparam int QW = $clog2(QUIET_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYCLES);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

   typedef enum logic [1:0] {
      ST_JOY    = 2'd0,
      ST_PEND_M = 2'd1,
      ST_MOUSE  = 2'd2,
      ST_PEND_J = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [QW-1:0]          quiet_q, quiet_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic [5:0]             port_data_q, port_data_d;
   logic [SYNC_STAGES-1:0] mclk_sync_q;
   logic                   mclk_prev_q;
   logic                   strobe_q;

   logic m_act, j_act, strobe_edge;
   logic owner_q, pend_q, pend_d;
   logic handover, enter_pend;

   // PS/2 clock crosses into clk_sys; idle level is high so reset to 1 to avoid a false edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mclk_sync_q <= '1;
         mclk_prev_q <= 1'b1;
      end else begin
         mclk_sync_q <= {mclk_sync_q[SYNC_STAGES-2:0], ps2_mouse_clk};
         mclk_prev_q <= mclk_sync_q[SYNC_STAGES-1];
      end
   end

   // Previous strobe level, used only to spot strobe activity (strobe itself passes straight to the mouse engine).
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= strobe_in;
      end
   end

   assign m_act       = mclk_prev_q & ~mclk_sync_q[SYNC_STAGES-1];
   assign j_act       = |joy;
   assign strobe_edge = strobe_in ^ strobe_q;

   assign owner_q = (state_q == ST_MOUSE) || (state_q == ST_PEND_J);
   assign pend_q  = (state_q == ST_PEND_M) || (state_q == ST_PEND_J);

   // Next state, counters and port data; a cancel always beats quiet expiry in the same cycle.
   always_comb begin
      state_d     = state_q;
      handover    = 1'b0;
      case (state_q)
         ST_JOY: begin
            if (m_act && !j_act && (hold_q == '0)) state_d = ST_PEND_M;
         end
         ST_PEND_M: begin
            if (j_act) begin
               state_d = ST_JOY;
            end else if (quiet_q == QUIET_MAX) begin
               state_d  = ST_MOUSE;
               handover = 1'b1;
            end
         end
         ST_MOUSE: begin
            if (j_act && (hold_q == '0)) state_d = ST_PEND_J;
         end
         ST_PEND_J: begin
            if (m_act) begin
               state_d = ST_MOUSE;
            end else if (quiet_q == QUIET_MAX) begin
               state_d  = ST_JOY;
               handover = 1'b1;
            end
         end
         default: state_d = ST_JOY;
      endcase

      pend_d     = (state_d == ST_PEND_M) || (state_d == ST_PEND_J);
      enter_pend = pend_d && !pend_q;

      quiet_d = quiet_q;
      if (strobe_edge || enter_pend) begin
         quiet_d = '0;
      end else if (quiet_q != QUIET_MAX) begin
         quiet_d = quiet_q + QW'(1);
      end

      hold_d = hold_q;
      if (handover) begin
         hold_d = HOLD_LOAD;
      end else if (hold_q != '0) begin
         hold_d = hold_q - HW'(1);
      end

      // The current owner keeps driving through PEND; the new owner shows one edge after the state flips.
      if (owner_q) begin
         port_data_d = mouse_data;
      end else begin
         port_data_d = ~{joy[5], joy[4], joy[0], joy[1], joy[2], joy[3]};
      end
   end

   // State, counters and output register; soft reset overrides every other event.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_JOY;
         quiet_q     <= '0;
         hold_q      <= '0;
         port_data_q <= 6'h3F;
      end else if (soft_rst) begin
         state_q     <= ST_JOY;
         quiet_q     <= '0;
         hold_q      <= '0;
         port_data_q <= 6'h3F;
      end else begin
         state_q     <= state_d;
         quiet_q     <= quiet_d;
         hold_q      <= hold_d;
         port_data_q <= port_data_d;
      end
   end

   assign port_data   = port_data_q;
   assign owner_mouse = owner_q;
   assign pending     = pend_q;

`ifdef JOYPORT_SWCOUNT_EN
   logic [7:0] sw_count_q;

   // Completed handovers only; cancelled requests never reach the handover flag.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sw_count_q <= 8'h00;
      end else if (soft_rst) begin
         sw_count_q <= 8'h00;
      end else if (handover && (sw_count_q != 8'hFF)) begin
         sw_count_q <= sw_count_q + 8'h01;
      end
   end

   assign sw_count = sw_count_q;
`endif

endmodule

// File: tb/tb_joyport_owner_arbiter.sv
// Purpose : self-checking bench for joyport_owner_arbiter with small QUIET/HOLD values.
// Latency : reference model advances once per clk_sys rising edge; outputs sampled on the falling edge.
// Backpres: n/a.
module tb_joyport_owner_arbiter;

   localparam int Q = 20;
   localparam int H = 60;
   localparam int S = 2;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic       soft_rst;
   logic [5:0] joy;
   logic       ps2_mouse_clk;
   logic [5:0] mouse_data;
   logic       strobe_in;
   logic [5:0] port_data;
   logic       owner_mouse;
   logic       pending;
`ifdef JOYPORT_SWCOUNT_EN
   logic [7:0] sw_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk_sys = ~clk_sys;

   joyport_owner_arbiter #(
      .QUIET_CYCLES(Q),
      .HOLD_CYCLES (H),
      .SYNC_STAGES (S)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .soft_rst     (soft_rst),
      .joy          (joy),
      .ps2_mouse_clk(ps2_mouse_clk),
      .mouse_data   (mouse_data),
      .strobe_in    (strobe_in),
      .port_data    (port_data),
      .owner_mouse  (owner_mouse),
      .pending      (pending)
`ifdef JOYPORT_SWCOUNT_EN
      ,
      .sw_count     (sw_count)
`endif
   );

   // Reference model: absolute edge numbers of the last quiet restart and last handover.
   int         edge_n = 0;
   int         m_clr;
   int         m_hedge;
   bit         m_owner;
   bit         m_pend;
   logic [5:0] m_port;
   int         m_sw;
   bit         m_sprev;
   bit         hist[$];

   function automatic logic [5:0] pad_to_port(input logic [5:0] j);
      logic up, down, left, right, fire1, fire2;
      right = j[0]; left = j[1]; down = j[2]; up = j[3]; fire1 = j[4]; fire2 = j[5];
      return ~{fire2, fire1, right, left, down, up};
   endfunction

   task automatic m_reset();
      m_owner = 0; m_pend = 0; m_port = 6'h3F; m_sw = 0;
      m_clr = edge_n; m_hedge = edge_n - H; m_sprev = 0;
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_back(1'b1);
   endtask

   task automatic m_edge();
      int  e, quiet, hold;
      bit  mact, jact, sedge, want, cancel;
      edge_n++;
      e = edge_n;
      quiet = e - 1 - m_clr;
      if (quiet > Q) quiet = Q;
      hold = H - (e - 1 - m_hedge);
      if (hold < 0) hold = 0;
      hist.push_back(ps2_mouse_clk);
      if (hist.size() > 8) void'(hist.pop_front());
      mact  = hist[hist.size()-S-2] && !hist[hist.size()-S-1];
      sedge = (strobe_in != m_sprev);
      m_sprev = strobe_in;
      jact = (joy != 6'd0);
      if (soft_rst) begin
         m_owner = 0; m_pend = 0; m_port = 6'h3F; m_sw = 0;
         m_clr = e; m_hedge = e - H;
         return;
      end
      m_port = m_owner ? mouse_data : pad_to_port(joy);
      if (!m_pend) begin
         want = m_owner ? jact : (mact && !jact);
         if (want && hold == 0) begin
            m_pend = 1;
            m_clr  = e;
         end
      end else begin
         cancel = m_owner ? mact : jact;
         if (cancel) begin
            m_pend = 0;
         end else if (quiet == Q) begin
            m_pend  = 0;
            m_owner = !m_owner;
            m_hedge = e;
            if (m_sw < 255) m_sw++;
         end
      end
      if (sedge) m_clr = e;
   endtask

   task automatic step();
      @(posedge clk_sys);
      if (!reset_n) m_reset();
      else m_edge();
      @(negedge clk_sys);
   endtask

   task automatic test_reset();
      reset_n = 0; soft_rst = 0; joy = 0; ps2_mouse_clk = 1; mouse_data = 6'h15; strobe_in = 0;
      m_reset();
      repeat (3) step();
      checks++; if (port_data !== 6'h3F) begin errors++; $display("FAIL reset_port: got %h want 3f", port_data); end
      checks++; if (owner_mouse !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b want 0", owner_mouse); end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
      reset_n = 1;
      step();
      checks++; if (pending !== 1'b0 || owner_mouse !== 1'b0) begin errors++; $display("FAIL reset_release: got own=%b pend=%b want 0 0", owner_mouse, pending); end
   endtask

   task automatic test_mapping();
      joy = 6'b000001; step();
      checks++; if (port_data !== 6'b110111) begin errors++; $display("FAIL map_right: got %b want 110111", port_data); end
      joy = 6'b010000; step();
      checks++; if (port_data !== 6'b101111) begin errors++; $display("FAIL map_fire1: got %b want 101111", port_data); end
      joy = 6'b000000; step();
      checks++; if (port_data !== 6'h3F) begin errors++; $display("FAIL map_idle: got %b want 111111", port_data); end
   endtask

   task automatic test_async_reset_mid_pend();
      int n;
      bit bad;
      ps2_mouse_clk = 0;
      n = 0; while (!pending && n < 8) begin step(); n++; end
      ps2_mouse_clk = 1;
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL arst_enter_pend: got %b want 1", pending); end
      step(); step();
      #2 reset_n = 0; m_reset();
      #1;
      checks++; if (port_data !== 6'h3F || owner_mouse !== 1'b0 || pending !== 1'b0) begin
         errors++; $display("FAIL arst_immediate: got port=%h own=%b pend=%b want 3f 0 0", port_data, owner_mouse, pending);
      end
      @(negedge clk_sys);
      step();
      reset_n = 1;
      bad = 0;
      repeat (Q + 10) begin step(); if (pending !== 1'b0 || owner_mouse !== 1'b0) bad = 1; end
      checks++; if (bad) begin errors++; $display("FAIL arst_stays_joy: got own=%b pend=%b want 0 0", owner_mouse, pending); end
   endtask

   task automatic test_handover();
      int n;
      mouse_data = 6'h15;
      ps2_mouse_clk = 0;
      n = 0; while (!pending && n < 8) begin step(); n++; end
      ps2_mouse_clk = 1;
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL ho_pending: got %b want 1", pending); end
      n = 0; while (!owner_mouse && n < Q + 10) begin step(); n++; end
      // quiet_cnt reaches Q, the state moves on the following edge
      checks++; if (n != Q + 1) begin errors++; $display("FAIL ho_quiet_time: got %0d want %0d", n, Q + 1); end
      checks++; if (port_data !== 6'h3F) begin errors++; $display("FAIL ho_switch_edge: got %h want 3f", port_data); end
      step();
      checks++; if (port_data !== 6'h15 || pending !== 1'b0) begin errors++; $display("FAIL ho_mouse_data: got %h pend=%b want 15 0", port_data, pending); end
   endtask

   task automatic test_strobe_quiet();
      int n;
      bit bad;
      soft_rst = 1; step(); soft_rst = 0;
      checks++; if (owner_mouse !== 1'b0 || pending !== 1'b0 || port_data !== 6'h3F) begin
         errors++; $display("FAIL softrst: got own=%b pend=%b port=%h want 0 0 3f", owner_mouse, pending, port_data);
      end
      ps2_mouse_clk = 0;
      n = 0; while (!pending && n < 8) begin step(); n++; end
      ps2_mouse_clk = 1;
      bad = !pending;
      for (int k = 0; k < 5; k++) begin
         strobe_in = ~strobe_in;
         repeat (Q / 2) begin step(); if (pending !== 1'b1 || owner_mouse !== 1'b0) bad = 1; end
      end
      checks++; if (bad) begin errors++; $display("FAIL strobe_holds_pend: got own=%b pend=%b want 0 1", owner_mouse, pending); end
      strobe_in = ~strobe_in;
      step();
      n = 0; while (!owner_mouse && n < Q + 10) begin step(); n++; end
      checks++; if (n != Q + 1) begin errors++; $display("FAIL strobe_quiet_time: got %0d want %0d", n, Q + 1); end
   endtask

   task automatic test_hold_and_cancel();
      int n;
      n = 0;
      repeat (10) begin step(); n++; end
      joy = 6'b000001;
      while (!pending && n < H + 20) begin step(); n++; end
      checks++; if (n != H + 1) begin errors++; $display("FAIL hold_time: got %0d want %0d", n, H + 1); end
      checks++; if (owner_mouse !== 1'b1) begin errors++; $display("FAIL pendj_owner: got %b want 1", owner_mouse); end
      ps2_mouse_clk = 0;
      n = 0; while (pending && n < 8) begin step(); n++; end
      ps2_mouse_clk = 1;
      checks++; if (pending !== 1'b0 || owner_mouse !== 1'b1) begin errors++; $display("FAIL cancel_to_mouse: got own=%b pend=%b want 1 0", owner_mouse, pending); end
      step();
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL cancel_no_hold: got %b want 1", pending); end
      joy = 6'b000000;
      n = 0; while (owner_mouse && n < Q + 10) begin step(); n++; end
      checks++; if (n != Q + 1 || owner_mouse !== 1'b0) begin errors++; $display("FAIL back_to_joy: got n=%0d own=%b want %0d 0", n, owner_mouse, Q + 1); end
   endtask

   task automatic test_joy_hold_and_swcount();
      int n;
      bit bad;
      ps2_mouse_clk = 0;
      bad = 0;
      repeat (6) begin step(); if (pending !== 1'b0) bad = 1; end
      ps2_mouse_clk = 1;
      checks++; if (bad) begin errors++; $display("FAIL joy_hold_blocks: got pend=%b want 0", pending); end
      repeat (H) step();
      ps2_mouse_clk = 0;
      n = 0; while (!pending && n < 8) begin step(); n++; end
      ps2_mouse_clk = 1;
      n = 0; while (!owner_mouse && n < Q + 10) begin step(); n++; end
      checks++; if (owner_mouse !== 1'b1) begin errors++; $display("FAIL third_handover: got %b want 1", owner_mouse); end
`ifdef JOYPORT_SWCOUNT_EN
      checks++; if (sw_count !== 8'd3) begin errors++; $display("FAIL sw_count_3: got %0d want 3", sw_count); end
`endif
      soft_rst = 1; step(); soft_rst = 0;
      checks++; if (owner_mouse !== 1'b0 || pending !== 1'b0) begin errors++; $display("FAIL softrst_mouse: got own=%b pend=%b want 0 0", owner_mouse, pending); end
`ifdef JOYPORT_SWCOUNT_EN
      checks++; if (sw_count !== 8'd0) begin errors++; $display("FAIL sw_count_clr: got %0d want 0", sw_count); end
`endif
   endtask

   task automatic test_random();
      soft_rst = 1; step(); soft_rst = 0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 99) < 5) joy = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         if ($urandom_range(0, 99) < 10) ps2_mouse_clk = ~ps2_mouse_clk;
         if ($urandom_range(0, 99) < 3) strobe_in = ~strobe_in;
         soft_rst   = ($urandom_range(0, 999) < 2);
         mouse_data = 6'($urandom);
         step();
         checks++; if (port_data !== m_port) begin errors++; $display("FAIL rnd_port c=%0d: got %h want %h", c, port_data, m_port); end
         checks++; if (owner_mouse !== m_owner) begin errors++; $display("FAIL rnd_owner c=%0d: got %b want %b", c, owner_mouse, m_owner); end
         checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pending c=%0d: got %b want %b", c, pending, m_pend); end
`ifdef JOYPORT_SWCOUNT_EN
         checks++; if (sw_count !== 8'(m_sw)) begin errors++; $display("FAIL rnd_swcount c=%0d: got %0d want %0d", c, sw_count, m_sw); end
`endif
      end
      soft_rst = 0;
   endtask

   initial begin
      test_reset();
      test_mapping();
      test_async_reset_mid_pend();
      test_handover();
      test_strobe_quiet();
      test_hold_and_cancel();
      test_joy_hold_and_swcount();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
